mdio_mgmt_sched: RTL and testbench



---
 rtl/mdio_mgmt_sched.sv | 128 ++++++++++++
 tb/tb_mdio_mgmt_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdio_mgmt_sched.sv
// mdio_mgmt_sched: round-robin CPU/link-poller scheduler for one MDIO master; ports: clk/rst, picosoc iomem slave (valid/ready/wstrb/addr/wdata/rdata), MDIO master request (m_*), link_up level and link_irq pulse
module mdio_mgmt_sched #(
  parameter int         POLL_CYCLES    = 1000000,
  parameter int         TIMEOUT_CYCLES = 8192,
  parameter logic [4:0] POLL_PHY       = 5'd0,
  parameter logic [4:0] POLL_REG       = 5'd1,
  parameter int         LINK_BIT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        m_valid,
  output logic        m_write,
  output logic [4:0]  m_phy,
  output logic [4:0]  m_reg,
  output logic [15:0] m_wdata,
  input  logic        m_ready,
  input  logic [15:0] m_rdata,
  output logic        link_up,
  output logic        link_irq
);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, CPU_XFER, POLL_XFER, CPU_RESP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic poll_en_q, poll_en_d, poll_pending_q, poll_pending_d, sticky_q, sticky_d, last_grant_q, last_grant_d;
  logic iomem_ready_q, iomem_ready_d, m_valid_q, m_valid_d, m_write_q, m_write_d;
  logic link_up_q, link_up_d, link_irq_q, link_irq_d;
  logic [31:0] iomem_rdata_q, iomem_rdata_d;
  logic [4:0] m_phy_q, m_phy_d, m_reg_q, m_reg_d;
  logic [15:0] m_wdata_q, m_wdata_d;
  logic sel_phy, sel_csr, grant_csr, grant_cpu, grant_poll, xfer, tmo, done, cpu_done, poll_wrap, csr_wr, link_chg;
  logic [31:0] csr_val;
  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:13], iomem_addr[7:5], iomem_wdata[31:16]};
  assign sel_phy    = iomem_valid && iomem_addr[31:24] == 8'h07;
  assign sel_csr    = iomem_valid && iomem_addr[31:24] == 8'h08;
  assign grant_csr  = state_q == IDLE && sel_csr;
  assign grant_cpu  = state_q == IDLE && !sel_csr && sel_phy && (!poll_pending_q || last_grant_q);
  assign grant_poll = state_q == IDLE && !sel_csr && poll_pending_q && (!sel_phy || !last_grant_q);
  assign xfer       = state_q == CPU_XFER || state_q == POLL_XFER;
  assign tmo        = xfer && !m_ready && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign done       = xfer && (m_ready || tmo);
  assign cpu_done   = state_q == CPU_XFER && done;
  assign poll_wrap  = poll_en_q && poll_cnt_q == PW'(POLL_CYCLES - 1);
  assign csr_wr     = grant_csr && iomem_wstrb[0];
  assign link_chg   = state_q == POLL_XFER && m_ready && m_rdata[LINK_BIT] != link_up_q;
  assign csr_val    = {28'b0, poll_pending_q, sticky_q, link_up_q, poll_en_q};
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = grant_csr || cpu_done ? CPU_RESP :
              grant_cpu ? CPU_XFER :
              grant_poll ? POLL_XFER :
              state_q == CPU_RESP || (state_q == POLL_XFER && done) ? IDLE : state_q;
  end
  always_comb begin
    poll_cnt_d     = !poll_en_q || poll_wrap ? '0 : poll_cnt_q + 1'b1;
    poll_pending_d = poll_wrap || (poll_pending_q && !grant_poll);
    tmo_cnt_d      = xfer && !done ? tmo_cnt_q + 1'b1 : '0;
    last_grant_d   = grant_cpu ? 1'b0 : grant_poll ? 1'b1 : last_grant_q;
    poll_en_d      = csr_wr ? iomem_wdata[0] : poll_en_q;
    sticky_d       = tmo || (sticky_q && !(csr_wr && iomem_wdata[1]));
    m_valid_d      = grant_cpu || grant_poll || (m_valid_q && !done);
    m_write_d      = grant_cpu ? |iomem_wstrb : grant_poll ? 1'b0 : m_write_q;
    m_phy_d        = grant_cpu ? iomem_addr[12:8] : grant_poll ? POLL_PHY : m_phy_q;
    m_reg_d        = grant_cpu ? iomem_addr[4:0] : grant_poll ? POLL_REG : m_reg_q;
    m_wdata_d      = grant_cpu ? iomem_wdata[15:0] : grant_poll ? 16'h0 : m_wdata_q;
    iomem_ready_d  = grant_csr || cpu_done;
    iomem_rdata_d  = grant_csr ? csr_val :
                     !cpu_done ? iomem_rdata_q :
                     m_write_q ? 32'h0 :
                     m_ready ? {16'h0, m_rdata} : 32'h0000_FFFF;
    link_up_d      = link_chg ? ~link_up_q : link_up_q;
    link_irq_d     = link_chg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      poll_en_q      <= 1'b0;
      poll_pending_q <= 1'b0;
      sticky_q       <= 1'b0;
      last_grant_q   <= 1'b1;
      iomem_ready_q  <= 1'b0;
      iomem_rdata_q  <= '0;
      m_valid_q      <= 1'b0;
      m_write_q      <= 1'b0;
      m_phy_q        <= '0;
      m_reg_q        <= '0;
      m_wdata_q      <= '0;
      link_up_q      <= 1'b0;
      link_irq_q     <= 1'b0;
    end else begin
      poll_cnt_q     <= poll_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      poll_en_q      <= poll_en_d;
      poll_pending_q <= poll_pending_d;
      sticky_q       <= sticky_d;
      last_grant_q   <= last_grant_d;
      iomem_ready_q  <= iomem_ready_d;
      iomem_rdata_q  <= iomem_rdata_d;
      m_valid_q      <= m_valid_d;
      m_write_q      <= m_write_d;
      m_phy_q        <= m_phy_d;
      m_reg_q        <= m_reg_d;
      m_wdata_q      <= m_wdata_d;
      link_up_q      <= link_up_d;
      link_irq_q     <= link_irq_d;
    end
  end
  assign iomem_ready = iomem_ready_q;
  assign iomem_rdata = iomem_rdata_q;
  assign m_valid     = m_valid_q;
  assign m_write     = m_write_q;
  assign m_phy       = m_phy_q;
  assign m_reg       = m_reg_q;
  assign m_wdata     = m_wdata_q;
  assign link_up     = link_up_q;
  assign link_irq    = link_irq_q;
endmodule

// File: tb/tb_mdio_mgmt_sched.sv
// tb_mdio_mgmt_sched: directed self-checking bench; dut_a polls every 16 cycles with a 64-cycle timeout, dut_b has an 8-cycle timeout and a silent master
module tb_mdio_mgmt_sched;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic valid_a = 0, valid_b = 0;
  logic [3:0] wstrb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ready_a, m_valid, m_write, m_ready, link_up, link_irq;
  logic [31:0] rdata_a;
  logic [4:0] m_phy, m_reg;
  logic [15:0] m_wdata, m_rdata;
  logic ready_b, mv_b, mw_b, link_b, irq_b;
  logic [31:0] rdata_b;
  logic [4:0] mphy_b, mreg_b;
  logic [15:0] mwd_b;
  logic mr_b = 0;
  logic [15:0] mrd_b = 0;
  mdio_mgmt_sched #(.POLL_CYCLES(16), .TIMEOUT_CYCLES(64)) dut_a (
    .clk(clk), .rst(rst), .iomem_valid(valid_a), .iomem_ready(ready_a), .iomem_wstrb(wstrb),
    .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata_a), .m_valid(m_valid), .m_write(m_write),
    .m_phy(m_phy), .m_reg(m_reg), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
    .link_up(link_up), .link_irq(link_irq));
  mdio_mgmt_sched #(.POLL_CYCLES(16), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .iomem_valid(valid_b), .iomem_ready(ready_b), .iomem_wstrb(wstrb),
    .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata_b), .m_valid(mv_b), .m_write(mw_b),
    .m_phy(mphy_b), .m_reg(mreg_b), .m_wdata(mwd_b), .m_ready(mr_b), .m_rdata(mrd_b),
    .link_up(link_b), .link_irq(irq_b));
  localparam logic [31:0] CSR = 32'h0800_0000;
  int n_chk = 0, n_err = 0;
  int cpu_delay = 40, poll_delay = 2, w = 0;
  logic [15:0] cpu_data = 16'h0;
  logic [15:0] poll_q[$];
  bit glog[$];
  int n_irq = 0, n_rise = 0, n_fall = 0, mv_b_cnt = 0;
  logic prev_mv = 0, prev_link = 0, chg;
  logic cap_w;
  logic [4:0] cap_phy, cap_reg;
  logic [15:0] cap_wd;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic acc(input bit b, input logic [31:0] ad, input logic [3:0] ws, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    bit got;
    @(negedge clk);
    addr = ad; wstrb = ws; wdata = wd;
    if (b) valid_b = 1; else valid_a = 1;
    lat = 0; got = 0;
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      got = b ? ready_b : ready_a;
    end
    chk("acc_ready", got, 1);
    rd = b ? rdata_b : rdata_a;
    @(negedge clk);
    valid_a = 0; valid_b = 0;
    @(posedge clk); #1;
    chk("ready_pulse", b ? ready_b : ready_a, 0);
  endtask
  initial begin
    m_ready = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (m_ready) begin
        m_ready = 0; w = 0;
      end else if (m_valid && !rst) begin
        w++;
        if (m_phy == 5'd0 && m_reg == 5'd1 && !m_write) begin
          if (w >= poll_delay) begin
            m_ready = 1;
            m_rdata = poll_q.size() != 0 ? poll_q.pop_front() : 16'h0;
          end
        end else if (w >= cpu_delay) begin
          m_ready = 1; m_rdata = cpu_data;
        end
      end else w = 0;
    end
  end
  initial forever begin
    @(posedge clk); #1;
    if (m_valid && !prev_mv) begin
      glog.push_back(m_phy == 5'd0 && m_reg == 5'd1 && !m_write);
      cap_w = m_write; cap_phy = m_phy; cap_reg = m_reg; cap_wd = m_wdata;
    end
    if (!rst) begin
      chg = link_up != prev_link;
      if (chg || link_irq) chk("irq_vs_link", link_irq, chg);
      if (link_irq) begin
        n_irq++;
        chk("irq_lat", m_ready, 1);
      end
      if (chg && link_up) n_rise++;
      if (chg && !link_up) n_fall++;
    end
    prev_mv = m_valid; prev_link = link_up;
    if (mv_b) mv_b_cnt++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    int lat, cnt;
    bit found;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {ready_a, rdata_a, m_valid, m_write, m_phy, m_reg, m_wdata, link_up, link_irq}, 64'h0);
    @(negedge clk) rst = 0;
    acc(0, CSR, 4'h0, 32'h0, rd, lat);
    chk("rst_csr", rd, 32'h0);
    cpu_delay = 40; cpu_data = 16'h0141;
    acc(0, 32'h0700_0502, 4'h0, 32'h0, rd, lat);
    chk("rd_data", rd, 32'h0000_0141);
    chk("rd_lat", lat, 41);
    chk("rd_fields", {cap_w, cap_phy, cap_reg}, {1'b0, 5'd5, 5'd2});
    cpu_delay = 3;
    acc(0, 32'h0700_0000, 4'hF, 32'hABCD_1200, rd, lat);
    chk("wr_data", rd, 32'h0);
    chk("wr_lat", lat, 4);
    chk("wr_fields", {cap_w, cap_phy, cap_reg, cap_wd}, {1'b1, 5'd0, 5'd0, 16'h1200});
    acc(0, 32'h0700_0103, 4'h2, 32'h0000_55AA, rd, lat);
    chk("wr_partial_strobe", {cap_w, cap_phy, cap_reg, cap_wd}, {1'b1, 5'd1, 5'd3, 16'h55AA});
    @(negedge clk);
    addr = 32'h0900_0502; wstrb = 0; valid_a = 1; cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready_a || m_valid) cnt++;
    end
    chk("ignored_addr", cnt, 0);
    @(negedge clk) valid_a = 0;
    poll_q.push_back(16'h0004);
    poll_q.push_back(16'h0000);
    poll_delay = 2;
    acc(0, CSR, 4'h1, 32'h1, rd, lat);
    chk("csr_lat", lat, 1);
    for (int i = 0; i < 200 && n_irq < 2; i++) @(posedge clk);
    #1;
    chk("irq_count", n_irq, 2);
    chk("link_rise", n_rise, 1);
    chk("link_fall", n_fall, 1);
    chk("link_final", link_up, 0);
    acc(0, CSR, 4'h1, 32'h0, rd, lat);
    @(negedge clk) rst = 1;
    @(posedge clk);
    @(negedge clk) rst = 0;
    glog.delete();
    cpu_delay = 5;
    acc(0, CSR, 4'h1, 32'h1, rd, lat);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      acc(0, CSR, 4'h0, 32'h0, rd, lat);
      found = rd[3];
    end
    chk("pend_seen", found, 1);
    acc(0, 32'h0700_0304, 4'h0, 32'h0, rd, lat);
    acc(0, 32'h0700_0304, 4'h0, 32'h0, rd, lat);
    chk("tie_order", glog.size() >= 3 ? {glog[0], glog[1], glog[2]} : 3'b111, 3'b010);
    mv_b_cnt = 0;
    acc(1, 32'h0700_0102, 4'h0, 32'h0, rd, lat);
    chk("tmo_data", rd, 32'h0000_FFFF);
    chk("tmo_lat", lat, 9);
    chk("tmo_mvalid_cycles", mv_b_cnt, 8);
    acc(1, CSR, 4'h0, 32'h0, rd, lat);
    chk("tmo_sticky", rd, 32'h4);
    acc(1, CSR, 4'h1, 32'h2, rd, lat);
    acc(1, CSR, 4'h0, 32'h0, rd, lat);
    chk("sticky_clr", rd, 32'h0);
    poll_delay = 100;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      found = m_valid && m_phy == 5'd0 && m_reg == 5'd1 && !m_write;
    end
    chk("poll_started", found, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_mvalid", m_valid, 0);
    chk("rst_mid_outs", {ready_a, rdata_a, m_valid, m_write, m_phy, m_reg, m_wdata, link_up, link_irq}, 64'h0);
    @(negedge clk) rst = 0;
    acc(0, CSR, 4'h0, 32'h0, rd, lat);
    chk("rst_mid_csr", rd, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
